// File: rtl/core_id_issue.sv
// core_id_issue: single-entry decode-to-execute issue register with operand bypass, load-use interlock and flush
module core_id_issue #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int RFIDX_W = 5,
  parameter int BJ_W    = 8,
  parameter int ALU_W   = 16,
  parameter int LSU_W   = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [PC_W-1:0]    i_pc,
  input  logic               i_branch_predict,
  input  logic               i_rs1_ren,
  input  logic               i_rs2_ren,
  input  logic               i_rd_wen,
  input  logic [RFIDX_W-1:0] i_rs1_idx,
  input  logic [RFIDX_W-1:0] i_rs2_idx,
  input  logic [RFIDX_W-1:0] i_rd_idx,
  input  logic [XLEN-1:0]    i_imm,
  input  logic [BJ_W-1:0]    i_bj_bus,
  input  logic [ALU_W-1:0]   i_alu_bus,
  input  logic [LSU_W-1:0]   i_lsu_bus,
  output logic [RFIDX_W-1:0] rf_rs1_idx,
  output logic [RFIDX_W-1:0] rf_rs2_idx,
  input  logic [XLEN-1:0]    rf_rs1_dat,
  input  logic [XLEN-1:0]    rf_rs2_dat,
  input  logic               ex_fwd_valid,
  input  logic               ex_fwd_wen,
  input  logic [RFIDX_W-1:0] ex_fwd_idx,
  input  logic [XLEN-1:0]    ex_fwd_dat,
  input  logic               ex_fwd_pending,
  input  logic               wb_en,
  input  logic [RFIDX_W-1:0] wb_idx,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush_req,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_branch_predict,
  output logic               o_rs1_ren,
  output logic               o_rs2_ren,
  output logic               o_rd_wen,
  output logic [RFIDX_W-1:0] o_rs1_idx,
  output logic [RFIDX_W-1:0] o_rs2_idx,
  output logic [RFIDX_W-1:0] o_rd_idx,
  output logic [XLEN-1:0]    o_imm,
  output logic [BJ_W-1:0]    o_bj_bus,
  output logic [ALU_W-1:0]   o_alu_bus,
  output logic [LSU_W-1:0]   o_lsu_bus,
  output logic [XLEN-1:0]    o_rs1_dat,
  output logic [XLEN-1:0]    o_rs2_dat,
  output logic [CNT_W-1:0]   stall_cnt
);
  logic hold_valid, ex_live, haz, issue, accept;
  assign rf_rs1_idx = o_rs1_idx;
  assign rf_rs2_idx = o_rs2_idx;
  // bypass priority x0 > EX > WB > regfile; hazard blocks issue while the EX producer is still pending
  always_comb begin
    ex_live   = ex_fwd_valid & ex_fwd_wen;
    o_rs1_dat = (o_rs1_idx == '0) ? '0 : (ex_live && ex_fwd_idx == o_rs1_idx) ? ex_fwd_dat :
                (wb_en && wb_idx == o_rs1_idx) ? wb_data : rf_rs1_dat;
    o_rs2_dat = (o_rs2_idx == '0) ? '0 : (ex_live && ex_fwd_idx == o_rs2_idx) ? ex_fwd_dat :
                (wb_en && wb_idx == o_rs2_idx) ? wb_data : rf_rs2_dat;
    haz       = hold_valid & ex_fwd_pending & ex_live & (ex_fwd_idx != '0) &
                ((o_rs1_ren & (ex_fwd_idx == o_rs1_idx)) | (o_rs2_ren & (ex_fwd_idx == o_rs2_idx)));
    valid_out = hold_valid & ~haz & ~flush_req;
    issue     = valid_out & ready_out;
    ready_in  = ~flush_req & (~hold_valid | issue);
    accept    = valid_in & ready_in;
  end
  // issue register: flush empties, accept loads, issue alone drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid       <= 1'b0;
      o_pc             <= '0;
      o_branch_predict <= 1'b0;
      o_rs1_ren        <= 1'b0;
      o_rs2_ren        <= 1'b0;
      o_rd_wen         <= 1'b0;
      o_rs1_idx        <= '0;
      o_rs2_idx        <= '0;
      o_rd_idx         <= '0;
      o_imm            <= '0;
      o_bj_bus         <= '0;
      o_alu_bus        <= '0;
      o_lsu_bus        <= '0;
    end else if (flush_req) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid       <= 1'b1;
      o_pc             <= i_pc;
      o_branch_predict <= i_branch_predict;
      o_rs1_ren        <= i_rs1_ren;
      o_rs2_ren        <= i_rs2_ren;
      o_rd_wen         <= i_rd_wen;
      o_rs1_idx        <= i_rs1_idx;
      o_rs2_idx        <= i_rs2_idx;
      o_rd_idx         <= i_rd_idx;
      o_imm            <= i_imm;
      o_bj_bus         <= i_bj_bus;
      o_alu_bus        <= i_alu_bus;
      o_lsu_bus        <= i_lsu_bus;
    end else if (issue) begin
      hold_valid <= 1'b0;
    end
  end
  // saturating count of cycles a held instruction fails to issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (hold_valid && !flush_req && !issue && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_core_id_issue.sv
// tb_core_id_issue: directed and random checks of core_id_issue against a queue-based reference model
module tb_core_id_issue;
  typedef struct packed {
    logic [31:0] pc;
    logic        bp;
    logic        r1en, r2en, rdwen;
    logic [4:0]  r1, r2, rd;
    logic [31:0] imm;
    logic [7:0]  bj;
    logic [15:0] alu;
    logic [7:0]  lsu;
  } ins_t;
  logic clk = 0, rst = 1;
  logic valid_in = 0, ready_out = 0, flush_req = 0;
  logic ex_fwd_valid = 0, ex_fwd_wen = 0, ex_fwd_pending = 0, wb_en = 0;
  logic [4:0] ex_fwd_idx = 0, wb_idx = 0;
  logic [31:0] ex_fwd_dat = 0, wb_data = 0, rf_rs1_dat = 0, rf_rs2_dat = 0;
  ins_t di = '0, dout, last, snap;
  logic ready_in, valid_out;
  logic [4:0] rf_rs1_idx, rf_rs2_idx;
  logic [31:0] o_rs1_dat, o_rs2_dat, stall_cnt, mcnt, c0;
  logic [31:0] o_pc, o_imm;
  logic o_bp, o_r1en, o_r2en, o_rdwen;
  logic [4:0] o_r1, o_r2, o_rd;
  logic [7:0] o_bj, o_lsu;
  logic [15:0] o_alu;
  ins_t q[$];
  int checks = 0, errors = 0;
  logic m_issue, m_accept;
  always #10 clk = ~clk;
  assign dout = {o_pc, o_bp, o_r1en, o_r2en, o_rdwen, o_r1, o_r2, o_rd, o_imm, o_bj, o_alu, o_lsu};
  core_id_issue dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .i_pc(di.pc), .i_branch_predict(di.bp), .i_rs1_ren(di.r1en), .i_rs2_ren(di.r2en), .i_rd_wen(di.rdwen),
    .i_rs1_idx(di.r1), .i_rs2_idx(di.r2), .i_rd_idx(di.rd), .i_imm(di.imm),
    .i_bj_bus(di.bj), .i_alu_bus(di.alu), .i_lsu_bus(di.lsu),
    .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx), .rf_rs1_dat(rf_rs1_dat), .rf_rs2_dat(rf_rs2_dat),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_wen(ex_fwd_wen), .ex_fwd_idx(ex_fwd_idx), .ex_fwd_dat(ex_fwd_dat),
    .ex_fwd_pending(ex_fwd_pending), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .flush_req(flush_req), .valid_out(valid_out), .ready_out(ready_out),
    .o_pc(o_pc), .o_branch_predict(o_bp), .o_rs1_ren(o_r1en), .o_rs2_ren(o_r2en), .o_rd_wen(o_rdwen),
    .o_rs1_idx(o_r1), .o_rs2_idx(o_r2), .o_rd_idx(o_rd), .o_imm(o_imm),
    .o_bj_bus(o_bj), .o_alu_bus(o_alu), .o_lsu_bus(o_lsu),
    .o_rs1_dat(o_rs1_dat), .o_rs2_dat(o_rs2_dat), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] eop(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 0;
    if (ex_fwd_valid && ex_fwd_wen && ex_fwd_idx == idx) return ex_fwd_dat;
    if (wb_en && wb_idx == idx) return wb_data;
    return rf;
  endfunction
  task automatic mreset();
    q.delete();
    last = '0;
    mcnt = 0;
  endtask
  task automatic tick();
    logic full, blocked, vo, ri;
    #1;
    full = q.size() != 0;
    blocked = ex_fwd_pending && ex_fwd_valid && ex_fwd_wen && ex_fwd_idx != 0 &&
              ((last.r1en && last.r1 == ex_fwd_idx) || (last.r2en && last.r2 == ex_fwd_idx));
    vo = full && !blocked && !flush_req;
    m_issue = vo && ready_out;
    ri = !flush_req && (!full || m_issue);
    m_accept = valid_in && ri;
    chk("valid_out", valid_out, vo);
    chk("ready_in", ready_in, ri);
    chk("fields", dout, last);
    chk("rf_idx", {rf_rs1_idx, rf_rs2_idx}, {last.r1, last.r2});
    chk("rs1_dat", o_rs1_dat, eop(last.r1, rf_rs1_dat));
    chk("rs2_dat", o_rs2_dat, eop(last.r2, rf_rs2_dat));
    chk("stall_cnt", stall_cnt, mcnt);
    @(posedge clk);
    if (full && !flush_req && !m_issue && mcnt != 32'hffff_ffff) mcnt++;
    if (m_issue) void'(q.pop_front());
    if (m_accept) begin
      q.push_back(di);
      last = di;
    end
    if (flush_req) q.delete();
    @(negedge clk);
  endtask
  function automatic ins_t rnd_ins();
    ins_t t;
    t = {$urandom, $urandom, $urandom, $urandom};
    t.r1 = 5'($urandom_range(0, 3));
    t.r2 = 5'($urandom_range(0, 3));
    return t;
  endfunction
  initial begin
    mreset();
    #3;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_ready_in", ready_in, 1'b1);
    chk("rst_fields", dout, 0);
    chk("rst_stall", stall_cnt, 0);
    @(negedge clk);
    rst = 0;
    ready_out = 1;
    valid_in = 1;
    for (int i = 0; i < 4; i++) begin
      di = rnd_ins();
      di.pc = 32'h8000_0000 + 32'(4 * i);
      tick();
      chk("b2b_valid", valid_out, 1'b1);
      chk("b2b_pc", o_pc, 32'h8000_0000 + 32'(4 * i));
    end
    valid_in = 0;
    tick();
    di = '0;
    di.r1 = 5;
    di.r1en = 1;
    valid_in = 1;
    ready_out = 0;
    tick();
    valid_in = 0;
    {ex_fwd_valid, ex_fwd_wen, ex_fwd_idx, ex_fwd_dat} = {2'b11, 5'd5, 32'h1234};
    {wb_en, wb_idx, wb_data} = {1'b1, 5'd5, 32'h9999};
    rf_rs1_dat = 1;
    #1 chk("byp_ex", o_rs1_dat, 32'h1234);
    ex_fwd_valid = 0;
    #1 chk("byp_wb", o_rs1_dat, 32'h9999);
    wb_en = 0;
    #1 chk("byp_rf", o_rs1_dat, 32'h1);
    tick();
    di = '0;
    di.r1 = 3;
    di.r2 = 7;
    di.r2en = 1;
    valid_in = 1;
    ready_out = 1;
    tick();
    valid_in = 0;
    {ex_fwd_valid, ex_fwd_wen, ex_fwd_pending, ex_fwd_idx} = {3'b111, 5'd7};
    c0 = stall_cnt;
    for (int i = 0; i < 3; i++) begin
      #1 chk("haz_valid", valid_out, 1'b0);
      chk("haz_ready", ready_in, 1'b0);
      tick();
    end
    chk("haz_cnt", stall_cnt - c0, 3);
    ex_fwd_pending = 0;
    ex_fwd_dat = 32'hABCD;
    #1 chk("haz_release", {valid_out, o_rs2_dat}, {1'b1, 32'hABCD});
    tick();
    di = '0;
    di.r1en = 1;
    valid_in = 1;
    ready_out = 0;
    tick();
    valid_in = 0;
    {ex_fwd_valid, ex_fwd_wen, ex_fwd_pending, ex_fwd_idx, ex_fwd_dat} = {3'b111, 5'd0, 32'hFFFF};
    #1 chk("x0_op", {valid_out, o_rs1_dat}, {1'b1, 32'h0});
    tick();
    {ex_fwd_valid, ex_fwd_wen, ex_fwd_pending} = 0;
    flush_req = 1;
    valid_in = 1;
    di = rnd_ins();
    #1 chk("flush_cycle", {valid_out, ready_in}, 2'b00);
    tick();
    flush_req = 0;
    #1 chk("post_flush", {valid_out, ready_in}, 2'b01);
    tick();
    valid_in = 0;
    chk("refill", valid_out, 1'b1);
    snap = dout;
    c0 = stall_cnt;
    tick();
    tick();
    chk("bp_stable", dout, snap);
    chk("bp_cnt", stall_cnt - c0, 2);
    rst = 1;
    #1 chk("async_rst", {valid_out, stall_cnt}, 33'h0);
    mreset();
    rst = 0;
    tick();
    for (int i = 0; i < 500; i++) begin
      valid_in = 1'($urandom);
      ready_out = $urandom_range(0, 3) != 0;
      flush_req = $urandom_range(0, 15) == 0;
      di = rnd_ins();
      {ex_fwd_valid, ex_fwd_wen} = 2'($urandom);
      ex_fwd_pending = $urandom_range(0, 3) == 0;
      ex_fwd_idx = 5'($urandom_range(0, 3));
      wb_en = 1'($urandom);
      wb_idx = 5'($urandom_range(0, 3));
      {ex_fwd_dat, wb_data, rf_rs1_dat, rf_rs2_dat} = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
